// File: rtl/pe_border_dbuf.sv
// -----------------------------------------------------------------------------
// pe_border_dbuf
//
// Border processing element for the left edge of a systolic PE row.
// It holds a double-buffered signed weight: a shadow register that is loaded
// from the weight chain, and an active register that the shadow is swapped
// into on command. The registered input feature is multiplied by the active
// weight in its own pipeline stage. The product is then used in one of two ways:
//   - weight-stationary (WS): the product is added to the incoming partial sum.
//   - output-stationary (OS): DEPTH products are accumulated locally, then the
//     total is emitted.
// Sums are either clamped to the signed OWIDTH range (SAT=1) or wrapped (SAT=0).
//
// Handshake: there is no backpressure. ofm_vld is a single-cycle strobe, and
// ofm_d holds the new result during that cycle. The consumer must take every
// strobe. ifm_vld and wght_ld are plain qualifiers on their data buses.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset; overrides every other input
//   clr        synchronous flush of the accumulator, the count and the valids
//   mode_os    0 = weight-stationary, 1 = output-stationary
//   ifm        signed input feature;      ifm_vld  its qualifier
//   wght       signed weight for shadow;  wght_ld  load it into the shadow
//   w_swap     copy the shadow into the active weight
//   ofm        incoming partial sum (WS only), aligned with the product stage
//   ifm_d      ifm registered toward the right neighbour; ifm_vld_d likewise
//   wght_d     wght registered on wght_ld; wght_ld_d is wght_ld registered
//   ofm_d      result register;  ofm_vld  one-cycle "result is new" strobe
// -----------------------------------------------------------------------------
module pe_border_dbuf #(
    parameter int IWIDTH = 8,
    parameter int OWIDTH = 24,
    parameter int DEPTH  = 16,
    parameter int SAT    = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     mode_os,
    input  logic signed [IWIDTH-1:0] ifm,
    input  logic                     ifm_vld,
    input  logic signed [IWIDTH-1:0] wght,
    input  logic                     wght_ld,
    input  logic                     w_swap,
    input  logic signed [OWIDTH-1:0] ofm,
    output logic signed [IWIDTH-1:0] ifm_d,
    output logic                     ifm_vld_d,
    output logic signed [IWIDTH-1:0] wght_d,
    output logic                     wght_ld_d,
    output logic signed [OWIDTH-1:0] ofm_d,
    output logic                     ofm_vld
);

    localparam int PW = 2 * IWIDTH;
    localparam int CW = $clog2(DEPTH);

    localparam logic [CW-1:0]     CNT_LAST = CW'(DEPTH - 1);
    localparam logic [OWIDTH-1:0] OMAX     = {1'b0, {(OWIDTH-1){1'b1}}};
    localparam logic [OWIDTH-1:0] OMIN     = {1'b1, {(OWIDTH-1){1'b0}}};

    // Pipeline and state registers
    logic signed [IWIDTH-1:0] ifm_q;
    logic                     ifm_vld_q;
    logic signed [IWIDTH-1:0] wght_q;
    logic                     wght_ld_q;
    logic signed [IWIDTH-1:0] shadow_q;
    logic signed [IWIDTH-1:0] w_act_q;
    logic signed [PW-1:0]     prod_q;
    logic                     prod_vld_q;
    logic signed [OWIDTH-1:0] acc_q;
    logic [CW-1:0]            cnt_q;
    logic                     mode_q;
    logic signed [OWIDTH-1:0] res_q;
    logic                     res_vld_q;

    // Next-state signals
    logic signed [PW-1:0]     prod_d;
    logic signed [OWIDTH-1:0] acc_d;
    logic [CW-1:0]            cnt_d;
    logic signed [OWIDTH-1:0] res_d;
    logic                     res_vld_d;

    // Combinational helpers
    logic                     mode_chg;
    logic signed [OWIDTH-1:0] acc_base;
    logic [CW-1:0]            cnt_base;
    logic signed [OWIDTH-1:0] prod_ext;
    logic signed [OWIDTH-1:0] addend;
    logic signed [OWIDTH-1:0] sum;

    // The sum is formed one bit wider than OWIDTH. A difference between the
    // top two bits signals an overflow of the signed OWIDTH range.
    function automatic logic signed [OWIDTH-1:0] add_sat(
        input logic signed [OWIDTH-1:0] a,
        input logic signed [OWIDTH-1:0] b
    );
        logic signed [OWIDTH:0]   s;
        logic signed [OWIDTH-1:0] r;
        s = {a[OWIDTH-1], a} + {b[OWIDTH-1], b};
        r = s[OWIDTH-1:0];
        if ((SAT != 0) && (s[OWIDTH] != s[OWIDTH-1])) begin
            r = s[OWIDTH] ? OMIN : OMAX;
        end
        add_sat = r;
    endfunction

    // Both operands are sign-extended to the full product width, so the
    // multiply is done at 2*IWIDTH bits.
    assign prod_d = $signed({{IWIDTH{ifm_q[IWIDTH-1]}}, ifm_q})
                  * $signed({{IWIDTH{w_act_q[IWIDTH-1]}}, w_act_q});

    always_comb begin
        // On a mode change, the accumulation restarts from zero. The product
        // in flight is already treated under the new mode (mode_os), so
        // mode_os, not mode_q, selects the behaviour below.
        mode_chg  = (mode_os != mode_q);
        acc_base  = mode_chg ? '0 : acc_q;
        cnt_base  = mode_chg ? '0 : cnt_q;
        prod_ext  = {{(OWIDTH-PW){prod_q[PW-1]}}, prod_q};
        addend    = mode_os ? acc_base : ofm;
        sum       = add_sat(addend, prod_ext);

        acc_d     = acc_base;
        cnt_d     = cnt_base;
        res_d     = res_q;
        res_vld_d = 1'b0;

        if (clr) begin
            // A flush suppresses any accumulate or emit in this cycle.
            acc_d = '0;
            cnt_d = '0;
        end else if (!mode_os) begin
            acc_d = '0;
            cnt_d = '0;
            if (prod_vld_q) begin
                res_d     = sum;
                res_vld_d = 1'b1;
            end
        end else if (prod_vld_q) begin
            if (cnt_base == CNT_LAST) begin
                // Emit the result and restart, so the next product begins a
                // new result without a bubble.
                res_d     = sum;
                res_vld_d = 1'b1;
                acc_d     = '0;
                cnt_d     = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_base + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ifm_q      <= '0;
            ifm_vld_q  <= 1'b0;
            wght_q     <= '0;
            wght_ld_q  <= 1'b0;
            shadow_q   <= '0;
            w_act_q    <= '0;
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
            acc_q      <= '0;
            cnt_q      <= '0;
            mode_q     <= 1'b0;
            res_q      <= '0;
            res_vld_q  <= 1'b0;
        end else begin
            ifm_q      <= ifm;
            ifm_vld_q  <= ifm_vld;
            wght_ld_q  <= wght_ld;
            if (wght_ld) begin
                shadow_q <= wght;
                wght_q   <= wght;
            end
            // On a simultaneous load and swap, the active weight receives the
            // pre-edge shadow value.
            if (w_swap) begin
                w_act_q <= shadow_q;
            end
            prod_q     <= prod_d;
            prod_vld_q <= clr ? 1'b0 : ifm_vld_q;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_os;
            res_q      <= res_d;
            res_vld_q  <= res_vld_d;
        end
    end

    assign ifm_d     = ifm_q;
    assign ifm_vld_d = ifm_vld_q;
    assign wght_d    = wght_q;
    assign wght_ld_d = wght_ld_q;
    assign ofm_d     = res_q;
    assign ofm_vld   = res_vld_q;

endmodule

// File: tb/tb_pe_border_dbuf.sv
module tb_pe_border_dbuf;
  localparam int IW = 8;
  localparam int OW = 24;
  localparam int DP = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n, rst_n_w, clr, mode_os, ifm_vld, wght_ld, w_swap;
  logic signed [IW-1:0] ifm, wght;
  logic signed [OW-1:0] ofm;

  logic signed [IW-1:0] ifm_d, wght_d, ifm_d_w, wght_d_w;
  logic                 ifm_vld_d, wght_ld_d, ofm_vld, ifm_vld_d_w, wght_ld_d_w, ofm_vld_w;
  logic signed [OW-1:0] ofm_d, ofm_d_w;

  pe_border_dbuf #(.IWIDTH(IW), .OWIDTH(OW), .DEPTH(DP), .SAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .mode_os(mode_os),
    .ifm(ifm), .ifm_vld(ifm_vld), .wght(wght), .wght_ld(wght_ld),
    .w_swap(w_swap), .ofm(ofm),
    .ifm_d(ifm_d), .ifm_vld_d(ifm_vld_d), .wght_d(wght_d), .wght_ld_d(wght_ld_d),
    .ofm_d(ofm_d), .ofm_vld(ofm_vld)
  );

  // Wrapping variant, held in reset until the wrap section.
  pe_border_dbuf #(.IWIDTH(IW), .OWIDTH(OW), .DEPTH(DP), .SAT(0)) u_wrap (
    .clk(clk), .rst_n(rst_n_w), .clr(clr), .mode_os(mode_os),
    .ifm(ifm), .ifm_vld(ifm_vld), .wght(wght), .wght_ld(wght_ld),
    .w_swap(w_swap), .ofm(ofm),
    .ifm_d(ifm_d_w), .ifm_vld_d(ifm_vld_d_w), .wght_d(wght_d_w), .wght_ld_d(wght_ld_d_w),
    .ofm_d(ofm_d_w), .ofm_vld(ofm_vld_w)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard queues: expected value plus the cycle on which it must appear.
  logic signed [OW-1:0] exp_q[$];
  int                   exp_cyc_q[$];
  logic signed [OW-1:0] exp_w_q[$];
  int                   exp_w_cyc_q[$];

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input int v);
    ifm     = v[IW-1:0];
    ifm_vld = 1'b1;
    tick();
    ifm_vld = 1'b0;
  endtask

  task automatic load_w(input int v);
    wght    = v[IW-1:0];
    wght_ld = 1'b1;
    tick();
    wght_ld = 1'b0;
  endtask

  task automatic swap();
    w_swap = 1'b1;
    tick();
    w_swap = 1'b0;
  endtask

  // Called right after the tick that sampled the last contributing ifm.
  task automatic expect_out(input logic signed [OW-1:0] v);
    exp_q.push_back(v);
    exp_cyc_q.push_back(cyc + 2);
  endtask

  task automatic expect_w(input logic signed [OW-1:0] v);
    exp_w_q.push_back(v);
    exp_w_cyc_q.push_back(cyc + 2);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    logic signed [OW-1:0] v;
    int c;
    if (ofm_vld === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ofm_unexpected got=%0d cyc=%0d", ofm_d, cyc);
      end else begin
        v = exp_q.pop_front();
        c = exp_cyc_q.pop_front();
        checks++;
        if (ofm_d !== v) begin
          errors++;
          $display("FAIL ofm_value got=%0d exp=%0d", ofm_d, v);
        end
        checks++;
        if (cyc != c) begin
          errors++;
          $display("FAIL ofm_timing got_cyc=%0d exp_cyc=%0d", cyc, c);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic signed [OW-1:0] v;
    int c;
    if (ofm_vld_w === 1'b1) begin
      if (exp_w_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wrap_unexpected got=%0d cyc=%0d", ofm_d_w, cyc);
      end else begin
        v = exp_w_q.pop_front();
        c = exp_w_cyc_q.pop_front();
        checks++;
        if (ofm_d_w !== v) begin
          errors++;
          $display("FAIL wrap_value got=%0d exp=%0d", ofm_d_w, v);
        end
        checks++;
        if (cyc != c) begin
          errors++;
          $display("FAIL wrap_timing got_cyc=%0d exp_cyc=%0d", cyc, c);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset with random inputs
    rst_n   = 1'b0;
    rst_n_w = 1'b0;
    ifm     = IW'($urandom_range(0, 255));
    ifm_vld = 1'($urandom_range(0, 1));
    wght    = IW'($urandom_range(0, 255));
    wght_ld = 1'($urandom_range(0, 1));
    w_swap  = 1'($urandom_range(0, 1));
    clr     = 1'($urandom_range(0, 1));
    mode_os = 1'($urandom_range(0, 1));
    ofm     = OW'($urandom_range(0, 65535));
    idle(2);
    chk("rst_ifm_d", ifm_d, 0);
    chk("rst_ifm_vld_d", ifm_vld_d, 0);
    chk("rst_wght_d", wght_d, 0);
    chk("rst_wght_ld_d", wght_ld_d, 0);
    chk("rst_ofm_d", ofm_d, 0);
    chk("rst_ofm_vld", ofm_vld, 0);

    ifm_vld = 1'b0; wght_ld = 1'b0; w_swap = 1'b0; clr = 1'b0; mode_os = 1'b0;
    ofm = '0; wght = '0; ifm = '0;

    // Release and forward; the product uses the reset weight of 0.
    rst_n = 1'b1;
    send(5);
    expect_out(0);
    chk("fwd_ifm_d", ifm_d, 5);
    chk("fwd_ifm_vld_d", ifm_vld_d, 1);

    // WS multiply-add: 7 * -3 + 100 = 79
    load_w(-3);
    chk("fwd_wght_d", wght_d, -3);
    chk("fwd_wght_ld_d", wght_ld_d, 1);
    swap();
    ofm = 100;
    send(7);
    expect_out(79);
    idle(3);

    // Positive clamp: 16384 + 8388607 clamps to 8388607
    load_w(-128);
    swap();
    ofm = 8388607;
    send(-128);
    expect_out(8388607);
    idle(3);

    // Negative clamp: -16256 + -8388608 clamps to -8388608
    load_w(127);
    swap();
    ofm = -8388608;
    send(-128);
    expect_out(-8388608);
    idle(3);

    // Double buffer: active 2, shadow 5; then load 9 together with a swap,
    // then a plain swap.
    ofm = 0;
    load_w(2);
    swap();
    load_w(5);
    send(10);                       // multiplied by 2
    expect_out(20);
    ifm = 10; ifm_vld = 1'b1;
    wght = 9; wght_ld = 1'b1; w_swap = 1'b1;
    tick();                         // active <- 5 (old shadow), shadow <- 9
    expect_out(50);
    wght_ld = 1'b0;
    chk("dbuf_wght_d", wght_d, 9);
    tick();                         // active <- 9
    expect_out(90);
    ifm_vld = 1'b0; w_swap = 1'b0;
    idle(3);

    // OS back-to-back with weight 3: 3*(1+2+3+4)=30, 3*(5+6+7+8)=78
    load_w(3);
    swap();
    mode_os = 1'b1;
    idle(2);
    for (int i = 1; i <= 8; i++) begin
      send(i);
      if (i == 4) expect_out(30);
      if (i == 8) expect_out(78);
    end
    idle(3);

    // OS with gaps in ifm_vld: 3*(1+2+3+4)=30
    send(1);
    idle(1);
    send(2);
    send(3);
    idle(1);
    send(4);
    expect_out(30);
    idle(3);

    // clr after two products: the next pulse needs 4 fresh products.
    send(5);
    send(6);
    idle(2);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 4; i++) send(1);
    expect_out(12);
    idle(3);

    // Mode change after two OS products. The product in flight at the
    // switch edge is handled as WS: 4*3 + 1000 = 1012.
    ofm = 1000;
    send(2);
    send(2);
    send(4);
    expect_out(1012);
    idle(1);
    mode_os = 1'b0;
    tick();
    idle(3);

    // Back to OS: a fresh result from four products.
    mode_os = 1'b1;
    idle(1);
    for (int i = 0; i < 4; i++) send(1);
    expect_out(12);
    idle(3);

    // Saturating versus wrapping DUT in WS mode
    mode_os = 1'b0;
    idle(2);
    rst_n_w = 1'b1;
    tick();
    load_w(-128);
    swap();
    ofm = 8388607;
    send(-128);
    expect_out(8388607);
    expect_w(-8372225);             // 8404991 - 2^24
    idle(3);
    load_w(127);
    swap();
    ofm = -8388608;
    send(-128);
    expect_out(-8388608);
    expect_w(8372352);              // -8404864 + 2^24
    idle(4);

    chk("pending_expected", 64'(exp_q.size()), 0);
    chk("pending_expected_wrap", 64'(exp_w_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
